// File: rtl/hazard_control_unit_pkg.sv
// Shared LC-3b pipeline types: hazard FSM states and the performance counter width.
package lc3b_types;

    localparam int lc3b_perf_width = 16;

    typedef enum logic [0:0] {
        HZ_RUN  = 1'b0,
        HZ_IND2 = 1'b1
    } hazard_state_t;

endpackage

// File: rtl/hazard_control_unit_if.sv
// Bundle of the hazard unit's request inputs, pipeline register controls and counters.
interface hazard_control_unit_if
    import lc3b_types::*;
#(
    parameter int CNT_WIDTH = lc3b_perf_width
) ();

    logic                 stall_forwarding;
    logic                 flush_forwarding;
    logic                 branch_taken;
    logic                 icache_read;
    logic                 icache_resp;
    logic                 dcache_read;
    logic                 dcache_write;
    logic                 dcache_resp;
    logic                 mem_indirect;
    logic                 indirect_phase;
    logic                 load_pc;
    logic                 load_if_id;
    logic                 load_id_ex;
    logic                 load_ex_mem;
    logic                 load_mem_wb;
    logic                 flush_if_id;
    logic                 flush_id_ex;
    logic                 flush_ex_mem;
    logic [CNT_WIDTH-1:0] stall_cycles;
    logic [CNT_WIDTH-1:0] flush_count;

    // The datapath side drives the requests and consumes the controls.
    modport master (
        output stall_forwarding, flush_forwarding, branch_taken,
               icache_read, icache_resp, dcache_read, dcache_write,
               dcache_resp, mem_indirect,
        input  indirect_phase, load_pc, load_if_id, load_id_ex,
               load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex,
               flush_ex_mem, stall_cycles, flush_count
    );

    modport slave (
        input  stall_forwarding, flush_forwarding, branch_taken,
               icache_read, icache_resp, dcache_read, dcache_write,
               dcache_resp, mem_indirect,
        output indirect_phase, load_pc, load_if_id, load_id_ex,
               load_ex_mem, load_mem_wb, flush_if_id, flush_id_ex,
               flush_ex_mem, stall_cycles, flush_count
    );

endinterface

// File: rtl/hazard_control_unit_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (inc && (r_count != {WIDTH{1'b1}})) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline control for the 5-stage LC-3b: freeze/branch/load-use priority,
// LDI/STI two-access sequencing and stall/flush performance counters.
module hazard_control_unit
    import lc3b_types::*;
#(
    parameter int CNT_WIDTH = lc3b_perf_width
) (
    input  logic                 clk,
    input  logic                 reset,
    hazard_control_unit_if.slave hz
);

    hazard_state_t r_state;
    hazard_state_t w_nextState;

    logic w_icacheWait;
    logic w_dcacheWait;
    logic w_indirectFetch;
    logic w_freeze;
    logic w_loadUse;
    logic w_stallInc;
    logic w_flushInc;

    // The pointer fetch completing still freezes the pipe so MEM can re-access with the pointer.
    assign w_icacheWait    = hz.icache_read & ~hz.icache_resp;
    assign w_dcacheWait    = (hz.dcache_read | hz.dcache_write) & ~hz.dcache_resp;
    assign w_indirectFetch = (r_state == HZ_RUN) & hz.mem_indirect & hz.dcache_resp;
    assign w_freeze        = w_icacheWait | w_dcacheWait | w_indirectFetch;
    assign w_loadUse       = hz.stall_forwarding | hz.flush_forwarding;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= HZ_RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            HZ_RUN: begin
                if (hz.mem_indirect && hz.dcache_resp) begin
                    w_nextState = HZ_IND2;
                end
            end
            HZ_IND2: begin
                if (hz.dcache_resp && !w_freeze) begin
                    w_nextState = HZ_RUN;
                end
            end
            default: w_nextState = HZ_RUN;
        endcase
    end

    always_comb begin
        hz.load_pc      = 1'b1;
        hz.load_if_id   = 1'b1;
        hz.load_id_ex   = 1'b1;
        hz.load_ex_mem  = 1'b1;
        hz.load_mem_wb  = 1'b1;
        hz.flush_if_id  = 1'b0;
        hz.flush_id_ex  = 1'b0;
        hz.flush_ex_mem = 1'b0;
        if (reset) begin
            hz.load_pc      = 1'b0;
            hz.load_if_id   = 1'b0;
            hz.load_id_ex   = 1'b0;
            hz.load_ex_mem  = 1'b0;
            hz.load_mem_wb  = 1'b0;
            hz.flush_if_id  = 1'b1;
            hz.flush_id_ex  = 1'b1;
            hz.flush_ex_mem = 1'b1;
        end else if (w_freeze) begin
            hz.load_pc      = 1'b0;
            hz.load_if_id   = 1'b0;
            hz.load_id_ex   = 1'b0;
            hz.load_ex_mem  = 1'b0;
            hz.load_mem_wb  = 1'b0;
        end else if (hz.branch_taken) begin
            hz.flush_if_id  = 1'b1;
            hz.flush_id_ex  = 1'b1;
            hz.flush_ex_mem = 1'b1;
        end else if (w_loadUse) begin
            hz.load_pc      = 1'b0;
            hz.load_if_id   = 1'b0;
            hz.load_id_ex   = 1'b0;
            hz.flush_ex_mem = 1'b1;
        end
    end

    assign hz.indirect_phase = (r_state == HZ_IND2);

    assign w_stallInc = ~reset & ~hz.load_pc;
    assign w_flushInc = ~reset & ~w_freeze & hz.branch_taken;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stallCounter (
        .clk   (clk),
        .reset (reset),
        .inc   (w_stallInc),
        .count (hz.stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flushCounter (
        .clk   (clk),
        .reset (reset),
        .inc   (w_flushInc),
        .count (hz.flush_count)
    );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed-vector bench for hazard_control_unit with hand-computed expectations.
module tb_hazard_control_unit;

    logic clk;
    logic reset;
    int   errorCount;
    int   checkCount;

    hazard_control_unit_if #(.CNT_WIDTH(16)) hzIf ();

    hazard_control_unit #(.CNT_WIDTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hzIf.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Argument order: reset, stall_fwd, flush_fwd, branch, icache rd/resp, dcache rd/wr/resp, indirect.
    task automatic applyStimulus(input logic rst, input logic sf, input logic ff, input logic br,
                                 input logic icRd, input logic icRsp, input logic dcRd,
                                 input logic dcWr, input logic dcRsp, input logic ind);
        reset                 = rst;
        hzIf.stall_forwarding = sf;
        hzIf.flush_forwarding = ff;
        hzIf.branch_taken     = br;
        hzIf.icache_read      = icRd;
        hzIf.icache_resp      = icRsp;
        hzIf.dcache_read      = dcRd;
        hzIf.dcache_write     = dcWr;
        hzIf.dcache_resp      = dcRsp;
        hzIf.mem_indirect     = ind;
        #1;
    endtask

    task automatic checkCtrl(input string tag, input logic [4:0] expLoad, input logic [2:0] expFlush);
        checkOutput({tag, "_load"}, {27'd0, hzIf.load_pc, hzIf.load_if_id, hzIf.load_id_ex,
                                     hzIf.load_ex_mem, hzIf.load_mem_wb}, {27'd0, expLoad});
        checkOutput({tag, "_flush"}, {29'd0, hzIf.flush_if_id, hzIf.flush_id_ex, hzIf.flush_ex_mem},
                    {29'd0, expFlush});
    endtask

    task automatic checkRegs(input string tag, input logic phase, input logic [15:0] stalls,
                             input logic [15:0] flushes);
        checkOutput({tag, "_phase"}, {31'd0, hzIf.indirect_phase}, {31'd0, phase});
        checkOutput({tag, "_stalls"}, {16'd0, hzIf.stall_cycles}, {16'd0, stalls});
        checkOutput({tag, "_flushes"}, {16'd0, hzIf.flush_count}, {16'd0, flushes});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errorCount = 0;
        checkCount = 0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkCtrl("reset", 5'b00000, 3'b111);
        step();
        checkRegs("after_reset", 0, 16'd0, 16'd0);

        applyStimulus(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        checkCtrl("normal", 5'b11111, 3'b000);
        step();
        checkRegs("normal", 0, 16'd0, 16'd0);

        // Load-use: exactly one bubble, then normal flow.
        applyStimulus(0, 1, 1, 0, 1, 1, 0, 0, 0, 0);
        checkCtrl("loaduse", 5'b00011, 3'b001);
        step();
        checkRegs("loaduse", 0, 16'd1, 16'd0);
        applyStimulus(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        checkCtrl("loaduse_next", 5'b11111, 3'b000);
        step();
        checkRegs("loaduse_next", 0, 16'd1, 16'd0);

        applyStimulus(0, 1, 0, 1, 1, 1, 0, 0, 0, 0);
        checkCtrl("branch", 5'b11111, 3'b111);
        step();
        checkRegs("branch", 0, 16'd1, 16'd1);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 1, 1, 0, 0, 0);
            checkCtrl($sformatf("dmiss%0d", i), 5'b00000, 3'b000);
            step();
        end
        applyStimulus(0, 0, 0, 0, 1, 1, 1, 0, 1, 0);
        checkCtrl("dmiss_resp", 5'b11111, 3'b000);
        step();
        checkRegs("dmiss", 0, 16'd4, 16'd1);

        // A branch seen under freeze must count once, when the freeze lifts.
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        checkCtrl("br_frozen", 5'b00000, 3'b000);
        step();
        checkRegs("br_frozen", 0, 16'd5, 16'd1);
        applyStimulus(0, 0, 0, 1, 0, 0, 0, 1, 1, 0);
        checkCtrl("br_release", 5'b11111, 3'b111);
        step();
        checkRegs("br_release", 0, 16'd5, 16'd2);

        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 0, 0, 1, 1, 1, 0, 0, 1);
            checkCtrl($sformatf("ldi_p0_%0d", i), 5'b00000, 3'b000);
            step();
            checkOutput("ldi_p0_phase", {31'd0, hzIf.indirect_phase}, 32'd0);
        end
        applyStimulus(0, 0, 0, 0, 1, 1, 1, 0, 1, 1);
        checkCtrl("ldi_ptr", 5'b00000, 3'b000);
        step();
        checkRegs("ldi_ptr", 1, 16'd8, 16'd2);
        applyStimulus(0, 0, 0, 0, 1, 1, 1, 0, 0, 1);
        checkCtrl("ldi_p1", 5'b00000, 3'b000);
        step();
        checkOutput("ldi_p1_phase", {31'd0, hzIf.indirect_phase}, 32'd1);
        applyStimulus(0, 0, 0, 0, 1, 1, 1, 0, 1, 1);
        checkCtrl("ldi_done", 5'b11111, 3'b000);
        step();
        checkRegs("ldi_done", 0, 16'd9, 16'd2);

        // An icache miss keeps the FSM in the final-access phase despite dcache_resp.
        applyStimulus(0, 0, 0, 0, 1, 1, 1, 0, 1, 1);
        step();
        checkRegs("ind_ic_enter", 1, 16'd10, 16'd2);
        applyStimulus(0, 0, 0, 0, 1, 0, 1, 0, 1, 1);
        checkCtrl("ind_ic_miss", 5'b00000, 3'b000);
        step();
        checkRegs("ind_ic_miss", 1, 16'd11, 16'd2);
        applyStimulus(0, 0, 0, 0, 1, 1, 1, 0, 1, 1);
        checkCtrl("ind_ic_hit", 5'b11111, 3'b000);
        step();
        checkRegs("ind_ic_hit", 0, 16'd11, 16'd2);

        applyStimulus(0, 0, 0, 0, 1, 1, 1, 0, 1, 1);
        step();
        checkRegs("rst_ind_enter", 1, 16'd12, 16'd2);
        applyStimulus(1, 0, 0, 0, 1, 1, 1, 0, 0, 1);
        checkCtrl("rst_ind", 5'b00000, 3'b111);
        step();
        checkRegs("rst_ind", 0, 16'd0, 16'd0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checkCtrl("late_resp", 5'b11111, 3'b000);
        step();
        checkRegs("late_resp", 0, 16'd0, 16'd0);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        repeat (65534) step();
        checkRegs("sat_pre", 0, 16'hFFFE, 16'd0);
        repeat (3) step();
        checkRegs("sat_top", 0, 16'hFFFF, 16'd0);
        step();
        checkRegs("sat_hold", 0, 16'hFFFF, 16'd0);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
